// File: rtl/uart_rx_ctrl.sv
// UART receive controller. It frames the serial line into start, data, parity and stop
// bits, using an oversampling tick counter and the majority-voted bit from data_sampling.
module uart_rx_ctrl #(
  parameter int PRESCALE   = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX_IN,
  input  logic                        sampled_bit,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  output logic [$clog2(PRESCALE)-1:0] edge_cnt,
  output logic                        data_samp_en,
  output logic [DATA_WIDTH-1:0]       P_DATA,
  output logic                        data_valid,
  output logic                        par_err,
  output logic                        stp_err
);

  localparam int EDGE_W = $clog2(PRESCALE);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [EDGE_W-1:0] EDGE_ZERO = {EDGE_W{1'b0}};
  localparam logic [EDGE_W-1:0] EDGE_ONE  = {{(EDGE_W-1){1'b0}}, 1'b1};
  localparam logic [EDGE_W-1:0] EDGE_LAST = {EDGE_W{1'b1}};
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Expected parity bit for a word: even parity gives the XOR of its bits, odd inverts it.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word, input logic odd);
    parity_bit = (^word) ^ odd;
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  logic [EDGE_W-1:0]       edge_cnt_r;
  logic [EDGE_W-1:0]       edge_cnt_s;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [DATA_WIDTH-1:0]   p_data_r;
  logic                    samp_en_r;
  logic                    data_valid_r;
  logic                    par_err_r;
  logic                    stp_err_r;
  logic                    par_en_r;
  logic                    par_typ_r;
  logic                    bit_end_s;
  logic                    start_entry_s;
  logic                    data_last_s;
  logic                    par_err_s;
  logic                    frame_good_s;

  assign bit_end_s     = (state_r != IDLE) && (edge_cnt_r == EDGE_LAST);
  assign start_entry_s = (state_r == IDLE) && (next_state_s == START);
  assign data_last_s   = (bit_cnt_r == BIT_LAST);
  assign par_err_s     = sampled_bit ^ parity_bit(shift_r, par_typ_r);
  assign frame_good_s  = (state_r == STOP) && bit_end_s && sampled_bit && !par_err_r;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a high start-bit sample is a line glitch and is dropped silently.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!RX_IN) next_state_s = START;
        else        next_state_s = IDLE;
      end
      START: begin
        if (bit_end_s && sampled_bit)       next_state_s = IDLE;
        else if (bit_end_s && !sampled_bit) next_state_s = DATA;
        else                                next_state_s = START;
      end
      DATA: begin
        if (bit_end_s && data_last_s) next_state_s = par_en_r ? PARITY : STOP;
        else                          next_state_s = DATA;
      end
      PARITY: begin
        if (bit_end_s) next_state_s = STOP;
        else           next_state_s = PARITY;
      end
      STOP: begin
        if (bit_end_s) next_state_s = IDLE;
        else           next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Tick counter next value: restarts at 0 in the first cycle of every busy state.
  always_comb begin
    edge_cnt_s = EDGE_ZERO;
    if (next_state_s == IDLE)          edge_cnt_s = EDGE_ZERO;
    else if (state_r == IDLE)          edge_cnt_s = EDGE_ZERO;
    else if (edge_cnt_r == EDGE_LAST)  edge_cnt_s = EDGE_ZERO;
    else                               edge_cnt_s = edge_cnt_r + EDGE_ONE;
  end

  // Tick counter and sampling enable, both registered against the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_r <= EDGE_ZERO;
      samp_en_r  <= 1'b0;
    end else begin
      edge_cnt_r <= edge_cnt_s;
      samp_en_r  <= (next_state_s != IDLE);
    end
  end

  // Frame configuration is captured once per frame so mid-frame changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else if (start_entry_s) begin
      par_en_r  <= PAR_EN;
      par_typ_r <= PAR_TYP;
    end else begin
      par_en_r  <= par_en_r;
      par_typ_r <= par_typ_r;
    end
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt_r <= BIT_ZERO;
      shift_r   <= DATA_ZERO;
    end else if (start_entry_s) begin
      bit_cnt_r <= BIT_ZERO;
      shift_r   <= shift_r;
    end else if ((state_r == DATA) && bit_end_s) begin
      bit_cnt_r <= bit_cnt_r + BIT_ONE;
      shift_r   <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  // Error flags hold from their bit end until the next frame starts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_r <= 1'b0;
      stp_err_r <= 1'b0;
    end else if (start_entry_s) begin
      par_err_r <= 1'b0;
      stp_err_r <= 1'b0;
    end else begin
      if ((state_r == PARITY) && bit_end_s) par_err_r <= par_err_s;
      else                                  par_err_r <= par_err_r;
      if ((state_r == STOP) && bit_end_s)   stp_err_r <= ~sampled_bit;
      else                                  stp_err_r <= stp_err_r;
    end
  end

  // Output word and its one-cycle valid strobe; errored frames leave P_DATA untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_data_r     <= DATA_ZERO;
      data_valid_r <= 1'b0;
    end else if (frame_good_s) begin
      p_data_r     <= shift_r;
      data_valid_r <= 1'b1;
    end else begin
      p_data_r     <= p_data_r;
      data_valid_r <= 1'b0;
    end
  end

  assign edge_cnt     = edge_cnt_r;
  assign data_samp_en = samp_en_r;
  assign P_DATA       = p_data_r;
  assign data_valid   = data_valid_r;
  assign par_err      = par_err_r;
  assign stp_err      = stp_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a majority-vote data_sampling stand-in, directed frames
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int PRESCALE = 16;
  localparam int DW       = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          sampled_bit;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [3:0]    edge_cnt;
  logic          data_samp_en;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_ctrl #(.PRESCALE(PRESCALE), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .sampled_bit(sampled_bit),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .edge_cnt(edge_cnt),
    .data_samp_en(data_samp_en), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  // data_sampling stand-in: three samples around mid-bit, majority vote
  logic [2:0] samp_r = 3'b111;
  always @(posedge CLK) begin
    if (data_samp_en && edge_cnt == 4'd7) samp_r[0] <= RX_IN;
    if (data_samp_en && edge_cnt == 4'd8) samp_r[1] <= RX_IN;
    if (data_samp_en && edge_cnt == 4'd9) samp_r[2] <= RX_IN;
  end
  assign sampled_bit = (samp_r[0] & samp_r[1]) | (samp_r[0] & samp_r[2]) | (samp_r[1] & samp_r[2]);

  // Output monitor: records every valid word and counts busy cycles
  logic [DW-1:0] got_mem [0:255];
  int            got_n = 0;
  int            samp_cycles = 0;
  always @(negedge CLK) begin
    if (data_valid) begin
      got_mem[got_n[7:0]] <= P_DATA;
      got_n <= got_n + 1;
    end
    if (data_samp_en) samp_cycles <= samp_cycles + 1;
  end

  int            n_cmp = 0;
  int            n_err = 0;
  int            got_rd = 0;
  int            len_base = 0;
  int            exp_len = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_pdata = 8'h00;
  logic          exp_perr = 1'b0;
  logic          exp_serr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (PRESCALE) @(negedge CLK);
  endtask

  // Drives one frame and updates the reference model from the framing rules.
  task automatic send_frame(input logic [DW-1:0] d, input logic en, input logic typ,
                            input logic pbit, input logic sbit);
    int ones;
    PAR_EN  = en;
    PAR_TYP = typ;
    drive_bit(1'b0);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (en) drive_bit(pbit);
    drive_bit(sbit);
    ones     = $countones(d) + (en ? int'(pbit) : 0);
    exp_perr = en && ((ones % 2) != int'(typ));
    exp_serr = !sbit;
    exp_len += (1 + DW + (en ? 1 : 0) + 1) * PRESCALE;
    if (!exp_perr && sbit) begin
      exp_q.push_back(d);
      exp_pdata = d;
    end
  endtask

  // Lets the line go idle, waits for the receiver to settle, then compares everything.
  task automatic check_idle(input string tag);
    int waited = 0;
    int nexp;
    RX_IN = 1'b1;
    while (data_samp_en && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    check_val({tag, "_idle_timeout"}, 32'(waited < 200), 32'd1);
    repeat (3) @(negedge CLK);
    nexp = exp_q.size();
    check_val({tag, "_len"}, samp_cycles - len_base, exp_len);
    check_val({tag, "_nvalid"}, got_n - got_rd, nexp);
    for (int i = 0; i < nexp; i++) begin
      if (got_rd < got_n) begin
        check_val({tag, "_word"}, 32'(got_mem[got_rd[7:0]]), 32'(exp_q[i]));
        got_rd++;
      end
    end
    exp_q.delete();
    got_rd = got_n;
    check_val({tag, "_pdata"}, 32'(P_DATA), 32'(exp_pdata));
    check_val({tag, "_par_err"}, 32'(par_err), 32'(exp_perr));
    check_val({tag, "_stp_err"}, 32'(stp_err), 32'(exp_serr));
    check_val({tag, "_samp_en"}, 32'(data_samp_en), 32'd0);
    check_val({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd0);
    len_base = samp_cycles;
    exp_len  = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pdata"}, 32'(P_DATA), 32'd0);
    check_val({tag, "_valid"}, 32'(data_valid), 32'd0);
    check_val({tag, "_par_err"}, 32'(par_err), 32'd0);
    check_val({tag, "_stp_err"}, 32'(stp_err), 32'd0);
    check_val({tag, "_samp_en"}, 32'(data_samp_en), 32'd0);
    check_val({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic          en;
    logic          typ;
    logic          pbit;
    logic          sbit;
    int            run;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    check_val("idle_wait_samp_en", 32'(data_samp_en), 32'd0);
    len_base = samp_cycles;

    // Plain 8N1 frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_idle("a5");
    // Even parity, good then bad parity bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    check_idle("3c_good");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    check_idle("3c_parerr");
    // Odd parity, stop bit low
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    check_idle("01_stperr");
    // Start-bit glitch: flags clear, no word
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    exp_perr = 1'b0;
    exp_serr = 1'b0;
    exp_len  = PRESCALE;
    check_idle("glitch");
    // Back-to-back frames
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_idle("b2b");
    // Reset in data bit 3 of a third frame
    d = 8'h5A;
    PAR_EN = 1'b0;
    drive_bit(1'b0);
    drive_bit(d[0]);
    drive_bit(d[1]);
    drive_bit(d[2]);
    RX_IN = d[3];
    repeat (8) @(negedge CLK);
    check_val("mid_busy", 32'(data_samp_en), 32'd1);
    #2 RST = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    check_all_zero("post_rst");
    check_val("post_rst_nvalid", got_n - got_rd, 32'd0);
    got_rd    = got_n;
    len_base  = samp_cycles;
    exp_len   = 0;
    exp_pdata = 8'h00;
    exp_perr  = 1'b0;
    exp_serr  = 1'b0;

    // Randomized frames, some back-to-back
    run = 0;
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      en   = 1'($urandom);
      typ  = 1'($urandom);
      pbit = 1'($countones(d) % 2) ^ typ;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 4) != 0);
      send_frame(d, en, typ, pbit, sbit);
      if (k == 15 || run >= 2 || $urandom_range(0, 1) == 0) begin
        check_idle("rand");
        repeat ($urandom_range(1, 5)) @(negedge CLK);
        run = 0;
      end else begin
        run++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter PRESCALE, default 16: oversampling ticks per bit; a power of two, at least 8.
REQ-002 Parameter DATA_WIDTH, default 8: data bits per frame.
REQ-003 CLK  in  1  oversampling clock; one tick per edge; all state updates on the rising edge.
REQ-004 RST  in  1  reset; asynchronous and active-high.
REQ-005 RX_IN  in  1  serial line; idles high.
REQ-006 sampled_bit  in  1  majority-voted bit from data_sampling; stable from edge_cnt = PRESCALE/2+1 to the end of the bit.
REQ-007 PAR_EN  in  1  1 = frame carries a parity bit.
REQ-008 PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-009 edge_cnt  out  $clog2(PRESCALE)  tick index within the current bit; drives data_sampling.
REQ-010 data_samp_en  out  1  sampling enable to data_sampling.
REQ-011 P_DATA  out  DATA_WIDTH  last good received word.
REQ-012 data_valid  out  1  one-cycle pulse when a good word is on P_DATA.
REQ-013 par_err  out  1  parity error flag of the current or last frame.
REQ-014 stp_err  out  1  stop-bit error flag of the current or last frame.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-016 Bit end SHALL be defined as the cycle in which edge_cnt = PRESCALE-1 in any non-IDLE state.
REQ-017 In IDLE: edge_cnt SHALL hold 0, data_samp_en SHALL be 0, and RX_IN = 0 SHALL move the FSM to START on the next edge.
REQ-018 In every non-IDLE state, edge_cnt SHALL increment by 1 each cycle, starting at 0 in the first cycle of the state, and SHALL wrap from PRESCALE-1 to 0; data_samp_en SHALL be 1.
REQ-019 On entry to START, the FSM SHALL latch PAR_EN and PAR_TYP, clear par_err and stp_err, and clear the bit counter; later changes to PAR_EN and PAR_TYP SHALL be ignored until the next START.
REQ-020 START bit end: sampled_bit = 0 SHALL move the FSM to DATA; sampled_bit = 1 SHALL be treated as a glitch, return the FSM to IDLE, and raise no error flag.
REQ-021 DATA bit end: sampled_bit SHALL be shifted in LSB first, so the first data bit lands in bit 0, and the bit counter SHALL increment.
REQ-022 After the DATA_WIDTH-th bit end, the FSM SHALL go to PARITY if the latched PAR_EN = 1, else to STOP.
REQ-023 PARITY bit end: par_err SHALL be set to (sampled_bit XOR ^shift_reg XOR latched PAR_TYP), and the FSM SHALL go to STOP.
REQ-024 STOP bit end: stp_err SHALL be set to ~sampled_bit, and the FSM SHALL go to IDLE.
REQ-025 STOP bit end with no parity error and sampled_bit = 1: P_DATA SHALL load shift_reg and data_valid SHALL be 1 for exactly the next cycle.
REQ-026 On an errored frame, P_DATA SHALL keep its previous value, data_valid SHALL stay 0, and the error flag SHALL hold until the next START entry or reset.
REQ-027 Back-to-back frames: RX_IN = 0 on the first IDLE cycle after STOP SHALL start a new frame; no idle cycles SHALL be required.
REQ-028 Frame length SHALL be (1 + DATA_WIDTH + PAR_EN + 1) x PRESCALE cycles in non-IDLE states.
REQ-029 RX_IN SHALL be ignored outside IDLE; only sampled_bit is evaluated at bit ends.

Reset
REQ-030 RST = 1 SHALL immediately, without a clock, force: state IDLE; edge_cnt, bit counter, shift_reg and P_DATA all 0; data_samp_en, data_valid, par_err and stp_err all 0.
REQ-031 RST asserted mid-frame SHALL abort the frame with no data_valid pulse; after release, the block SHALL wait in IDLE for the next falling edge of RX_IN.

Verification
REQ-032 The bench SHALL pair uart_rx_ctrl with data_sampling (PRESCALE = 16) and drive RX_IN at 16 CLK per bit.
REQ-033 PAR_EN = 0, frame 0x A5: data_valid pulses once, P_DATA = 0xA5, par_err = 0, stp_err = 0, frame length 160 cycles.
REQ-034 PAR_EN = 1, PAR_TYP = 0, 0x3C with parity bit 0, then 0x3C with parity bit 1: first frame gives P_DATA = 0x3C with data_valid; second gives par_err = 1, no data_valid, P_DATA still 0x3C.
REQ-035 PAR_EN = 1, PAR_TYP = 1, 0x01 with parity bit 0, stop bit driven 0: stp_err = 1, par_err = 0, no data_valid.
REQ-036 RX_IN low for 4 ticks, then high: FSM returns to IDLE after 16 cycles; no flags set; data_samp_en back to 0.
REQ-037 Two back-to-back frames 0xFF and 0x00; then RST pulsed during data bit 3 of a third frame: two data_valid pulses in order, then all outputs 0 and the FSM in IDLE.
